// File: rtl/lcg_stream_checker.sv
// lcg_stream_checker
//   Receive-side tracker for a 32-bit LCG word stream
//   (next = (A*prev + C) mod 2^LOG2_M). It locks onto the incoming sequence,
//   predicts every next word and flags mismatches while locked. A flywheel
//   prediction keeps tracking through isolated corrupted words.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ACQUIRE  | waiting for a seed word; the next valid sample becomes prev
//   TRACK    | unlocked, counting consecutive matches toward LOCK_COUNT
//   LOCKED   | locked; mismatches pulse, count and advance by prediction
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   clear        in   synchronous clear of err_count and sample_count
//   in_valid     in   in_data holds a sample this cycle
//   in_data      in   [31:0] sample word
//   locked       out  tracker locked
//   mismatch     out  one-cycle pulse: previous sample mismatched while locked
//   expected     out  [31:0] prediction for the next valid sample
//   err_count    out  [CNT_W-1:0] mismatches while locked, saturating
//   sample_count out  [CNT_W-1:0] valid samples seen, saturating
module lcg_stream_checker #(
    parameter int unsigned A          = 1103515245,
    parameter int unsigned C          = 12345,
    parameter int          LOG2_M     = 31,
    parameter int          LOCK_COUNT = 4,
    parameter int          LOSS_COUNT = 3,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             locked,
    output logic             mismatch,
    output logic [31:0]      expected,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [63:0] MASK64 = (64'h1 << LOG2_M) - 64'h1;
    localparam logic [31:0] MASK32 = MASK64[31:0];

    function automatic logic [31:0] lcg_next(input logic [31:0] x);
        logic [63:0] s;
        s = 64'(A) * {32'h0, x} + 64'(C);
        return 32'(s & MASK64);
    endfunction

    // Clear first, then apply this cycle's increment, saturating at all-ones.
    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt,
                                                  input logic clr,
                                                  input logic inc);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cnt;
        if (inc && (base != {CNT_W{1'b1}}))
            base = base + 1'b1;
        return base;
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       prev_q, prev_d;
    logic [31:0]       expected_d;
    logic [7:0]        match_run_q, match_run_d;
    logic [7:0]        miss_run_q, miss_run_d;
    logic              locked_d;
    logic              mismatch_d;
    logic              err_inc;
    logic              hit;
    logic [31:0]       masked_in;

    // expected holds lcg(prev), so the comparison uses the stored prediction
    // and only the update path needs a multiplier.
    assign hit       = (in_data == expected);
    assign masked_in = in_data & MASK32;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        locked_d    = locked;
        mismatch_d  = 1'b0;
        err_inc     = 1'b0;
        if (in_valid) begin
            case (state_q)
                ACQUIRE: begin
                    prev_d      = masked_in;
                    match_run_d = 8'd0;
                    state_d     = TRACK;
                end
                TRACK: begin
                    prev_d = masked_in;
                    if (hit) begin
                        if (match_run_q + 8'd1 == 8'(LOCK_COUNT)) begin
                            locked_d    = 1'b1;
                            miss_run_d  = 8'd0;
                            match_run_d = 8'd0;
                            state_d     = LOCKED;
                        end else begin
                            match_run_d = match_run_q + 8'd1;
                        end
                    end else begin
                        match_run_d = 8'd0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        prev_d     = in_data;
                        miss_run_d = 8'd0;
                    end else begin
                        mismatch_d = 1'b1;
                        err_inc    = 1'b1;
                        // flywheel: advance along the predicted sequence
                        prev_d     = expected;
                        if (miss_run_q + 8'd1 == 8'(LOSS_COUNT)) begin
                            locked_d   = 1'b0;
                            miss_run_d = 8'd0;
                            state_d    = ACQUIRE;
                        end else begin
                            miss_run_d = miss_run_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d  = ACQUIRE;
                    locked_d = 1'b0;
                end
            endcase
        end
        expected_d = in_valid ? lcg_next(prev_d) : expected;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACQUIRE;
            prev_q       <= '0;
            expected     <= '0;
            match_run_q  <= '0;
            miss_run_q   <= '0;
            locked       <= 1'b0;
            mismatch     <= 1'b0;
            err_count    <= '0;
            sample_count <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            expected     <= expected_d;
            match_run_q  <= match_run_d;
            miss_run_q   <= miss_run_d;
            locked       <= locked_d;
            mismatch     <= mismatch_d;
            err_count    <= sat_next(err_count, clear, err_inc);
            sample_count <= sat_next(sample_count, clear, in_valid);
        end
    end

endmodule

// File: doc/lcg_stream_checker.md
Name: lcg_stream_checker

Overview:
- Receive-side counterpart to the team's 32-bit LCG generator: consumes a stream of words claimed to come from that generator (A=1103515245, C=12345, M=2^31).
- Locks onto the sequence, predicts every next word, and flags mismatches.
- Sits at a link or DUT output to verify PRNG traffic end to end.
- Holds a "flywheel" prediction so a single corrupted word does not derail tracking.

Parameters:
- A, 1103515245, LCG multiplier (int unsigned)
- C, 12345, LCG increment (int unsigned)
- LOG2_M, 31, modulus is 2^LOG2_M; prediction is the low LOG2_M bits, upper bits zero
- LOCK_COUNT, 4, consecutive matches needed to declare lock (1..255)
- LOSS_COUNT, 3, consecutive mismatches while locked that drop lock (1..255)
- CNT_W, 16, width of the error and sample counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of err_count and sample_count only; lock state is kept
- in_valid  in  1  in_data is a sample this cycle; no backpressure, one sample per cycle accepted
- in_data  in  32  sample word
- locked  out  1  tracker locked
- mismatch  out  1  one-cycle pulse: the previous sample mismatched while locked
- expected  out  32  prediction for the next valid sample (zero-extended)
- err_count  out  CNT_W  mismatches while locked, saturating
- sample_count  out  CNT_W  valid samples seen, saturating

Behaviour:
- Reset (async assert, sync release):
  - FSM=ACQUIRE; prev, expected, run counters and all outputs are 0; locked=0, mismatch=0.
- Prediction: next = (A*prev + C) mod 2^LOG2_M.
  - Full 64-bit product truncated to LOG2_M bits.
  - Compare full 32 bits of in_data against the zero-extended prediction; any bit above LOG2_M set is a mismatch.
- All outputs are registered. The effect of a sample accepted at edge n is visible after edge n; `expected` always shows the prediction for the next sample.
- in_valid=0: no state change, except `mismatch` returns to 0.
- ACQUIRE, on valid:
  - prev <= in_data (bits above LOG2_M masked).
  - match_run <= 0.
  - Go to TRACK.
- TRACK (unlocked), on valid:
  - Match: prev <= in_data; match_run++. If match_run reaches LOCK_COUNT: locked <= 1, miss_run <= 0, go to LOCKED.
  - Mismatch: re-seed. prev <= in_data (masked), match_run <= 0, stay in TRACK.
  - No `mismatch` pulse and no err_count change while unlocked.
- LOCKED, on valid:
  - Match: prev <= in_data; miss_run <= 0.
  - Mismatch: mismatch <= 1 for one cycle; err_count++ (saturating); prev <= prediction (flywheel, not in_data); miss_run++.
  - If miss_run reaches LOSS_COUNT: locked <= 0, go to ACQUIRE (the next valid sample re-seeds).
- sample_count increments on every valid sample in every state and saturates at all-ones. err_count also saturates.
- clear and valid in the same cycle:
  - The counter is cleared, then that sample's increment is applied, so the counter reads 1 if the sample counts.
- rst_n asserted mid-stream: immediate return to reset values; no partial lock is retained.
- Back-to-back valid samples every cycle: full throughput, no bubbles required.

Test Plan:
- Lock from seed 0: after reset, valid samples 0, 12345, 1406932606, ... (correct LCG continuation, LOCK_COUNT=4) -> `expected` shows 12345 after the 1st sample; locked=1 after the 5th sample; mismatch never pulses; err_count=0; sample_count=5.
- Single corruption while locked: replace one word with 0xDEADBEEF, then continue the correct sequence -> mismatch pulses exactly 1 cycle; err_count=1; locked stays 1; the next correct word matches (flywheel).
- Loss of lock: while locked, send 3 consecutive wrong words (LOSS_COUNT=3) -> 3 mismatch pulses; err_count=3; locked=0 after the 3rd; a fresh sequence from seed 1 (1, 1103527590, ...) relocks after 5 samples.
- Unlocked re-seed and bit-31 rule: send 7, then 0x80000000|next(7), then the correct continuation -> word 2 is a mismatch and re-seeds; no mismatch pulse; err_count=0; lock reached only after 4 further matches counted from the re-seed.
- Gaps, clear and reset: insert in_valid=0 gaps between samples -> identical lock timing in valid-sample terms. Assert clear together with a valid sample -> sample_count=1, locked unchanged. Assert rst_n low asynchronously mid-cycle -> all outputs 0 without waiting for a clock edge.
- Saturation: with CNT_W=4, feed 20 samples -> sample_count stays at 15. Force 20 locked mismatches with LOSS_COUNT=255 -> err_count=15.
